// File: rtl/regfile_mp_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_if -- bus bundle for the two-write / two-read register file.
//
// Signals (direction as seen from the register file, i.e. the slave side):
//   we0/we1, waddr0/waddr1, wdata0/wdata1  in   two write ports (port 1 wins)
//   alloc_en, alloc_addr                    in   reserve a destination (busy)
//   ra_en/rb_en, ra_addr/rb_addr            in   two read ports
//   ra_data/rb_data, ra_busy/rb_busy        out  combinational read results
//   clr_req                                 in   request a full array clear
//   ready                                   out  high only while running
// ---------------------------------------------------------------------------
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] waddr0;
  logic [ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              alloc_en;
  logic [ADDR_W-1:0] alloc_addr;
  logic              ra_en;
  logic              rb_en;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic              ra_busy;
  logic              rb_busy;
  logic              clr_req;
  logic              ready;

  modport master (
    output we0, we1, waddr0, waddr1, wdata0, wdata1,
    output alloc_en, alloc_addr,
    output ra_en, rb_en, ra_addr, rb_addr, clr_req,
    input  ra_data, rb_data, ra_busy, rb_busy, ready
  );

  modport slave (
    input  we0, we1, waddr0, waddr1, wdata0, wdata1,
    input  alloc_en, alloc_addr,
    input  ra_en, rb_en, ra_addr, rb_addr, clr_req,
    output ra_data, rb_data, ra_busy, rb_busy, ready
  );
endinterface

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- multi-ported register file with per-entry busy (scoreboard)
// bits and a self-clearing walk.
//
// Ports:
//   clk  in   single clock, all state updates on the rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of regfile_mp_if (write/alloc/read ports, clr_req,
//        ready)
//
// Entry 0 is hard-wired zero. After reset or a clear request the array is
// zeroed one entry per cycle (entries 1..DEPTH-1); ready rises when that walk
// finishes. Writes and allocations are only accepted while running.
//
// Optional build macro: REGFILE_BYPASS_EN -- when defined, a read that hits
// an address being written in the same cycle returns the write data (port 1
// over port 0) with busy reported as 0. Undefined: reads see array contents
// only, so written data appears the cycle after the write.
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_ready;
  logic [DEPTH-1:0]  r_busy;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_commit;
  logic              w_we0;
  logic              w_we1;
  logic              w_alloc;
  logic [DEPTH-1:0]  w_busy_next;

  // Writes/allocs take effect only in RUN and only when no clear is being
  // requested in the same cycle; address 0 is never modified.
  assign w_commit = (r_state == ST_RUN) && !bus.clr_req;
  assign w_we0    = bus.we0      && (bus.waddr0     != '0);
  assign w_we1    = bus.we1      && (bus.waddr1     != '0);
  assign w_alloc  = bus.alloc_en && (bus.alloc_addr != '0);

  // -------------------------------------------------------------------------
  // Control FSM: CLEAR walks ptr from 1 to DEPTH-1, then RUN.
  // -------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_ptr   <= ADDR_W'(1);
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_ptr == ADDR_W'(DEPTH - 1)) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end else begin
            r_ptr <= r_ptr + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          // A request while clearing is ignored simply by not looking at it
          // in ST_CLEAR, so the walk is never restarted.
          if (bus.clr_req) begin
            r_state <= ST_CLEAR;
            r_ptr   <= ADDR_W'(1);
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ptr   <= ADDR_W'(1);
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Busy bits: a committed write clears, an allocation sets; allocation is
  // applied last so it wins on a same-address collision.
  // -------------------------------------------------------------------------
  // NOTE: blocking assignments in always_comb, with a full default first, so
  // later statements see earlier ones and no latch is inferred.
  always_comb begin
    w_busy_next = r_busy;
    if (w_we0)   w_busy_next[bus.waddr0]     = 1'b0;
    if (w_we1)   w_busy_next[bus.waddr1]     = 1'b0;
    if (w_alloc) w_busy_next[bus.alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_busy[r_ptr] <= 1'b0;
    end else if (w_commit) begin
      r_busy <= w_busy_next;
    end
  end

  // -------------------------------------------------------------------------
  // Data array. Port 1 is written after port 0 so it wins on a collision.
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset term; it is zeroed by the CLEAR walk, which
  // keeps it mappable onto plain RAM/flop arrays without a reset network.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_ptr] <= '0;
      end else if (w_commit) begin
        if (w_we0) r_mem[bus.waddr0] <= bus.wdata0;
        if (w_we1) r_mem[bus.waddr1] <= bus.wdata1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Combinational read ports; result packed as {busy, data}.
  // -------------------------------------------------------------------------
  function automatic logic [DATA_W:0] read_port(input logic              en,
                                                input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0] res;
    res = '0;
    if (!rst && r_ready && en && (addr != '0)) begin
      res = {r_busy[addr], r_mem[addr]};
`ifdef REGFILE_BYPASS_EN
      if (w_commit && w_we1 && (bus.waddr1 == addr)) begin
        res = {1'b0, bus.wdata1};
      end else if (w_commit && w_we0 && (bus.waddr0 == addr)) begin
        res = {1'b0, bus.wdata0};
      end
`endif
    end
    return res;
  endfunction

  assign {bus.ra_busy, bus.ra_data} = read_port(bus.ra_en, bus.ra_addr);
  assign {bus.rb_busy, bus.rb_data} = read_port(bus.rb_en, bus.rb_addr);
  assign bus.ready                  = r_ready;

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have ports we0/we1  input  1 each  meaning write enables, write ports 0 and 1.
REQ-006 SHALL have ports waddr0/waddr1  input  ADDR_W each  meaning write addresses.
REQ-007 SHALL have ports wdata0/wdata1  input  DATA_W each  meaning write data.
REQ-008 SHALL have port alloc_en  input  1  meaning reserve a destination register (set its busy bit).
REQ-009 SHALL have port alloc_addr  input  ADDR_W  meaning the register to reserve.
REQ-010 SHALL have ports ra_en/rb_en  input  1 each  meaning read enables, read ports A and B.
REQ-011 SHALL have ports ra_addr/rb_addr  input  ADDR_W each  meaning read addresses.
REQ-012 SHALL have ports ra_data/rb_data  output  DATA_W each  meaning read data.
REQ-013 SHALL have ports ra_busy/rb_busy  output  1 each  meaning busy bit of the addressed register.
REQ-014 SHALL have port clr_req  input  1  meaning request a full clear of the array.
REQ-015 SHALL have port ready  output  1  meaning registered flag, high only in state RUN.

Function
REQ-016 SHALL treat entry 0 as constant zero: reads return 0, busy 0; writes and allocs to it are ignored.
REQ-017 SHALL have read ports that are combinational: output 0 when rst=1, ready=0, en=0 or addr=0; otherwise the stored entry.
REQ-018 SHALL have read busy outputs equal to the registered busy bit; 0 under the same conditions as REQ-017.
REQ-019 SHALL, in RUN, commit writes at the clock edge; when both ports write the same address, port 1 wins.
REQ-020 SHALL have a committed write clear the busy bit of its address.
REQ-021 SHALL have alloc_en set the busy bit at the edge; on a same-address alloc and write in the same cycle, data is written and busy ends set (alloc wins).
REQ-022 SHALL leave busy set on an alloc to an already-busy register (no counting).
REQ-023 SHALL have an FSM with states CLEAR and RUN.
REQ-024 SHALL, in CLEAR, write one entry per cycle: entry[ptr]=0, busy[ptr]=0, ptr incrementing from 1; after ptr=DEPTH-1 the next state is RUN. Duration: DEPTH-1 cycles.
REQ-025 SHALL ignore writes and allocs in CLEAR.
REQ-026 SHALL, on clr_req in RUN, enter CLEAR with ptr=1 next edge; same-cycle writes/allocs are dropped. clr_req in CLEAR is ignored (walk not restarted).
REQ-027 SHALL have ready registered and rise on the first cycle of RUN.

Reset
REQ-028 SHALL, on rst=1 at an edge: state=CLEAR, ptr=1, ready=0, all busy bits 0. Reset mid-CLEAR restarts the walk from 1.
REQ-029 SHALL not reset the data array directly; it is zeroed only by the CLEAR walk.

Configuration
REQ-030 SHALL, with REGFILE_BYPASS_EN defined, in RUN, have a read whose address matches a same-cycle committed write (addr≠0) return that wdata (port 1 over port 0) and busy=0.
REQ-031 SHALL, without REGFILE_BYPASS_EN, have reads return array contents only; written data is visible the cycle after the write.

Verification
REQ-032 SHALL cover: rst 1 cycle, ADDR_W=5 -> ready low exactly 31 cycles after rst falls, then high; every read 0, busy 0.
REQ-033 SHALL cover: RUN, we0 addr 3 =0x11, we1 addr 3 =0x22 same cycle -> next cycle ra_addr=3 gives 0x00000022.
REQ-034 SHALL cover: alloc addr 7 -> rb_busy(7)=1 next cycle; write 0x5A to 7 -> busy 0 and data 0x5A next cycle; alloc+write 7 same cycle -> busy 1, data written.
REQ-035 SHALL cover: write 0xDEAD to 9 and read 9 same cycle -> 0xDEAD with REGFILE_BYPASS_EN, old value without.
REQ-036 SHALL cover: clr_req in RUN, then write during CLEAR -> write dropped, ready low 31 cycles, entry 9 reads 0 afterwards.
REQ-037 SHALL cover: rst asserted at ptr=10 mid-CLEAR -> walk restarts at 1, ready high 31 cycles after rst falls; write to addr 0 -> reads 0.
